// File: rtl/serial_word_tx_if.sv
// Word-in / bit-out bundle for serial_word_tx.
// master = transmitter view (takes the word, drives the serial side); slave = the source/sink around it.
interface serial_word_tx_if #(
    parameter int N = 32
);
    logic         inValid;
    logic         inReady;
    logic [N-1:0] din;
    logic         serEn;
    logic         serOut;
    logic         serValid;
    logic         frmFirst;
    logic         frmLast;
    logic         busy;

    modport master (
        input  inValid,
        input  din,
        input  serEn,
        output inReady,
        output serOut,
        output serValid,
        output frmFirst,
        output frmLast,
        output busy
    );

    modport slave (
        output inValid,
        output din,
        output serEn,
        input  inReady,
        input  serOut,
        input  serValid,
        input  frmFirst,
        input  frmLast,
        input  busy
    );
endinterface

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter, LSB first, with first/last frame markers.
// Latency: a word accepted at edge k shows bit 0 from edge k+1; back-to-back frames leave no gap.
// Backpressure: serEn low freezes the frame; SERIAL_WORD_TX_PARITY_EN appends an even-parity bit.
module serial_word_tx #(
    parameter int N = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    serial_word_tx_if.master      bus
);

    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

`ifdef SERIAL_WORD_TX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  sr;
    logic [N-1:0]  sr_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          last_bit;
    logic          accept;

`ifdef SERIAL_WORD_TX_PARITY_EN
    logic          par;
    logic          par_nxt;

    assign last_bit = (state == PARITY);
`else
    assign last_bit = (state == SHIFT) && (cnt == LAST);
`endif

    // The next word may be taken on the very edge that consumes the final bit.
    assign bus.inReady = !clr && ((state == IDLE) || (last_bit && bus.serEn));
    assign accept      = bus.inValid && bus.inReady;

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = cnt;
`ifdef SERIAL_WORD_TX_PARITY_EN
        par_nxt   = par;
`endif
        if (clr) begin
            state_nxt = IDLE;
            sr_nxt    = '0;
            cnt_nxt   = '0;
`ifdef SERIAL_WORD_TX_PARITY_EN
            par_nxt   = 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = IDLE;
                end
                SHIFT: begin
                    if (bus.serEn) begin
                        sr_nxt  = {1'b0, sr[N-1:1]};
                        cnt_nxt = cnt + 1'b1;
                        if (cnt == LAST) begin
                            cnt_nxt = '0;
`ifdef SERIAL_WORD_TX_PARITY_EN
                            state_nxt = PARITY;
`else
                            state_nxt = IDLE;
`endif
                        end
                    end
                end
`ifdef SERIAL_WORD_TX_PARITY_EN
                PARITY: begin
                    if (bus.serEn) begin
                        state_nxt = IDLE;
                    end
                end
`endif
                default: begin
                    state_nxt = IDLE;
                end
            endcase

            // Accept only happens from IDLE or the consumed final bit, so it overrides the above.
            if (accept) begin
                state_nxt = SHIFT;
                sr_nxt    = bus.din;
                cnt_nxt   = '0;
`ifdef SERIAL_WORD_TX_PARITY_EN
                par_nxt   = ^bus.din;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
`ifdef SERIAL_WORD_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            sr    <= sr_nxt;
            cnt   <= cnt_nxt;
`ifdef SERIAL_WORD_TX_PARITY_EN
            par   <= par_nxt;
`endif
        end
    end

    always_comb begin
        bus.serOut = 1'b0;
        if (state == SHIFT) begin
            bus.serOut = sr[0];
        end
`ifdef SERIAL_WORD_TX_PARITY_EN
        if (state == PARITY) begin
            bus.serOut = par;
        end
`endif
    end

    assign bus.serValid = (state != IDLE);
    assign bus.busy     = (state != IDLE);
    assign bus.frmFirst = (state == SHIFT) && (cnt == '0);
    assign bus.frmLast  = last_bit;

endmodule

// File: doc/serial_word_tx.md
# serial_word_tx

Parallel-to-serial word transmitter, the sending end of the shift-right serial links in the datapath. It accepts an N-bit word over a valid/ready handshake and drives it out LSB-first, one bit per consumed cycle, with first/last frame markers and downstream back-pressure. It pairs with a receiving shift register that shifts `serIn` into its MSB, so after N accepted shifts that register holds the original word.

## Interface
- `N`, 32, word width in bits; N ≥ 2.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous reset, active-low; forces IDLE.
- `clr`  in  1  synchronous clear, active-high; priority over all other inputs except `rst`.
- `inValid`  in  1  `din` holds a word to send.
- `inReady`  out  1  transmitter can accept a word this cycle.
- `din`  in  N  parallel word.
- `serEn`  in  1  downstream consumes the current bit this cycle.
- `serOut`  out  1  current serial bit.
- `serValid`  out  1  `serOut` is a frame bit.
- `frmFirst`  out  1  current bit is bit 0 of the frame.
- `frmLast`  out  1  current bit is the final bit of the frame.
- `busy`  out  1  a frame is in progress; equal to `serValid`.

## Operation
- State register: IDLE and SHIFT. PARITY exists only when `PARITY_EN` is defined.
- Datapath: N-bit shift register `sr` and a bit counter `cnt` of width clog2(N).
- `serOut` = `sr[0]` in SHIFT. It is the parity bit in PARITY and 0 in IDLE.
- Accept occurs when `inValid && inReady`:
  - `sr` <= `din`, `cnt` <= 0, next state SHIFT.
  - With `PARITY_EN`, the parity register <= ^`din`.
- `inReady` is combinational:
  - 1 in IDLE.
  - 1 in the final-bit state when `serEn` = 1.
  - 0 otherwise, and always 0 while `clr` = 1.
- SHIFT with `serEn` = 1:
  - `sr` <= {1'b0, `sr[N-1:1]`}, `cnt` <= `cnt` + 1.
  - At `cnt` = N-1, the next state is PARITY if enabled. Otherwise it is SHIFT on an accept and IDLE without one.
- SHIFT with `serEn` = 0: `sr`, `cnt` and all outputs hold.
- PARITY with `serEn` = 1: next state is SHIFT on an accept, otherwise IDLE. With `serEn` = 0 it holds.
- `frmFirst` = SHIFT && `cnt` = 0.
- `frmLast`:
  - Without `PARITY_EN`: SHIFT && `cnt` = N-1.
  - With `PARITY_EN`: the PARITY state.
- `clr`: `sr`, `cnt`, parity <= 0 and state <= IDLE. A partial frame is dropped and the word in flight is not accepted.
- `rst` low: the same as `clr`, but immediate. All registers clear asynchronously.

## Timing
- Reset/clear values: `serOut` = 0, `serValid` = 0, `frmFirst` = 0, `frmLast` = 0, `busy` = 0. `inReady` = 1 once `clr` and `rst` are deasserted.
- Latency: a word accepted at edge k drives bit 0 on `serOut` from edge k+1.
- With `serEn` held high, a frame occupies exactly N cycles, or N+1 with `PARITY_EN`.
- Back-to-back words produce no gap cycles. The next word is accepted on the edge that consumes the last bit.
- `inValid` is ignored when `inReady` = 0. The source must hold `din` until accepted.
- `clr` and an accept in the same cycle: `clr` wins and the word is not taken.
- Deasserting `rst` mid-frame resumes from IDLE. There is no partial replay.

## Configuration
- Macro `SERIAL_WORD_TX_PARITY_EN`.
- Defined: one even-parity bit (^`din`) is appended after bit N-1. `frmLast` marks the parity bit, and the frame is N+1 bits.
- Undefined: the PARITY state and parity register are absent. The frame is N bits and `frmLast` marks bit N-1.

## Test plan
All scenarios use N = 8.
1. Hold `rst` low for 3 cycles with `inValid` = 1 → `serValid` = 0, `serOut` = 0, `frmFirst` = `frmLast` = 0 throughout. After release, `inReady` = 1 and nothing is accepted during reset.
2. Send 8'hA5 with `serEn` = 1 and no parity → over 8 cycles `serOut` = 1,0,1,0,0,1,0,1. `frmFirst` is high only in cycle 1 and `frmLast` only in cycle 8. `inReady` = 1 in cycle 8 only.
3. Send 8'hA5 and drop `serEn` for 3 cycles while bit 3 (0) is shown → `serOut` stays 0, `serValid` stays 1, and `frmLast` is delayed by 3 cycles.
4. Hold `inValid` with 8'h01 then 8'h80, `serEn` = 1 → 16 consecutive `serValid` cycles with `serOut` = 1,0×7,0×7,1. `frmFirst` rises in cycles 1 and 9.
5. Pulse `clr` after 4 bits of 8'hFF → the next cycle shows `serValid` = 0 and `inReady` = 1. A new word 8'h0F then sends cleanly as 1,1,1,1,0,0,0,0.
6. With `SERIAL_WORD_TX_PARITY_EN`, send 8'h07 → 9 bits 1,1,1,0,0,0,0,0,1. `frmLast` is high only on the 9th bit.
